switch_rr_buffered: RTL and testbench

- Parametrised successor of the per-router output switch: an M_IN x N_OUT crossbar with one round-robin arbiter and one output FIFO per output port.
- Adds fair rotating-priority arbitration, optional wormhole packet locking (head/tail flits) and registered, buffered outputs with a valid/avail handshake.
- Sits between the router input queues (with route computation) and the link/eject interfaces.

---
 rtl/switch_rr_buffered.sv | 186 ++++++++++++++++++
 tb/tb_switch_rr_buffered.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/switch_rr_buffered.sv
// M_IN x N_OUT crossbar with a round-robin arbiter, optional wormhole lock and
// a small FIFO on each output port.
module switch_rr_buffered #(
    parameter int unsigned M_IN      = 6,
    parameter int unsigned N_OUT     = 6,
    parameter int unsigned FLIT_SIZE = 82,
    parameter int unsigned ROUTE_LEN = 3,
    parameter int unsigned OUT_DEPTH = 2,
    parameter bit          PKT_LOCK  = 1'b1,
    parameter int unsigned HEAD_BIT  = FLIT_SIZE - 1,
    parameter int unsigned TAIL_BIT  = FLIT_SIZE - 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [M_IN*FLIT_SIZE-1:0]  in,
    input  logic [M_IN*ROUTE_LEN-1:0]  route_in,
    input  logic [M_IN-1:0]            in_valid,
    output logic [M_IN-1:0]            in_avail,
    output logic [N_OUT-1:0]           out_valid,
    input  logic [N_OUT-1:0]           out_avail,
    output logic [N_OUT*FLIT_SIZE-1:0] out
);

    localparam int unsigned IDX_W = (M_IN > 1) ? $clog2(M_IN) : 1;
    localparam int unsigned PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(OUT_DEPTH + 1);

    logic [FLIT_SIZE-1:0] flit  [M_IN];
    logic [ROUTE_LEN-1:0] route [M_IN];

    logic [N_OUT-1:0][M_IN-1:0]  req;
    logic [N_OUT-1:0][M_IN-1:0]  grant;
    logic [N_OUT-1:0]            grant_vld;
    logic [N_OUT-1:0][IDX_W-1:0] grant_idx;
    logic [N_OUT-1:0]            space;
    logic [N_OUT-1:0]            push;
    logic [N_OUT-1:0]            pop;
    logic [FLIT_SIZE-1:0]        push_data [N_OUT];

    logic [N_OUT-1:0][CNT_W-1:0] count_q;
    logic [N_OUT-1:0][PTR_W-1:0] rd_ptr_q;
    logic [N_OUT-1:0][PTR_W-1:0] wr_ptr_q;
    logic [N_OUT-1:0][IDX_W-1:0] ptr_q;
    logic [N_OUT-1:0][IDX_W-1:0] owner_q;
    logic [N_OUT-1:0]            lock_q;
    logic [FLIT_SIZE-1:0]        mem_q [N_OUT][OUT_DEPTH];

    always_comb begin
        for (int unsigned i = 0; i < M_IN; i++) begin
            flit[i]  = in[i*FLIT_SIZE +: FLIT_SIZE];
            route[i] = route_in[i*ROUTE_LEN +: ROUTE_LEN];
        end
    end

    // Route value r selects output r-1; 0 and out-of-range values match nothing.
    always_comb begin
        req = '0;
        for (int unsigned j = 0; j < N_OUT; j++) begin
            for (int unsigned i = 0; i < M_IN; i++) begin
                req[j][i] = in_valid[i] && (32'(route[i]) == j + 1);
            end
        end
    end

    always_comb begin
        for (int unsigned j = 0; j < N_OUT; j++) begin
            space[j] = (count_q[j] < CNT_W'(OUT_DEPTH));
        end
    end

    always_comb begin
        int unsigned idx;
        grant     = '0;
        grant_vld = '0;
        grant_idx = '0;
        idx       = 0;
        for (int unsigned j = 0; j < N_OUT; j++) begin
            if (space[j]) begin
                if (PKT_LOCK && lock_q[j]) begin
                    if (req[j][owner_q[j]]) begin
                        grant[j][owner_q[j]] = 1'b1;
                        grant_vld[j]         = 1'b1;
                        grant_idx[j]         = owner_q[j];
                    end
                end else begin
                    for (int unsigned k = 0; k < M_IN; k++) begin
                        idx = 32'(ptr_q[j]) + k;
                        if (idx >= M_IN) begin
                            idx = idx - M_IN;
                        end
                        if (!grant_vld[j] && req[j][idx]) begin
                            grant[j][idx] = 1'b1;
                            grant_vld[j]  = 1'b1;
                            grant_idx[j]  = IDX_W'(idx);
                        end
                    end
                end
            end
        end
    end

    // Each input requests at most one output, so ORing grants cannot double-accept.
    always_comb begin
        in_avail = '0;
        for (int unsigned j = 0; j < N_OUT; j++) begin
            in_avail = in_avail | grant[j];
        end
        if (!rst) begin
            in_avail = '0;
        end
    end

    always_comb begin
        for (int unsigned j = 0; j < N_OUT; j++) begin
            push[j]      = grant_vld[j];
            pop[j]       = out_valid[j] && out_avail[j];
            push_data[j] = flit[grant_idx[j]];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            ptr_q    <= '0;
            owner_q  <= '0;
            lock_q   <= '0;
        end else begin
            for (int unsigned j = 0; j < N_OUT; j++) begin
                if (push[j]) begin
                    wr_ptr_q[j] <= (wr_ptr_q[j] == PTR_W'(OUT_DEPTH - 1)) ? '0
                                                                          : wr_ptr_q[j] + 1'b1;
                end
                if (pop[j]) begin
                    rd_ptr_q[j] <= (rd_ptr_q[j] == PTR_W'(OUT_DEPTH - 1)) ? '0
                                                                          : rd_ptr_q[j] + 1'b1;
                end
                if (push[j] && !pop[j]) begin
                    count_q[j] <= count_q[j] + 1'b1;
                end else if (!push[j] && pop[j]) begin
                    count_q[j] <= count_q[j] - 1'b1;
                end

                if (push[j]) begin
                    // Inside a packet the priority pointer freezes until the tail goes through.
                    if (!(PKT_LOCK && lock_q[j]) || push_data[j][TAIL_BIT]) begin
                        ptr_q[j] <= (grant_idx[j] == IDX_W'(M_IN - 1)) ? '0
                                                                       : grant_idx[j] + 1'b1;
                    end
                    if (PKT_LOCK) begin
                        if (lock_q[j]) begin
                            if (push_data[j][TAIL_BIT]) begin
                                lock_q[j] <= 1'b0;
                            end
                        end else if (push_data[j][HEAD_BIT] && !push_data[j][TAIL_BIT]) begin
                            lock_q[j]  <= 1'b1;
                            owner_q[j] <= grant_idx[j];
                        end
                    end
                end
            end
        end
    end

    // Storage needs no reset: out is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        for (int unsigned j = 0; j < N_OUT; j++) begin
            if (push[j]) begin
                mem_q[j][wr_ptr_q[j]] <= push_data[j];
            end
        end
    end

    always_comb begin
        out       = '0;
        out_valid = '0;
        for (int unsigned j = 0; j < N_OUT; j++) begin
            out_valid[j] = (count_q[j] != '0);
            if (out_valid[j]) begin
                out[j*FLIT_SIZE +: FLIT_SIZE] = mem_q[j][rd_ptr_q[j]];
            end
        end
    end

endmodule

// File: tb/tb_switch_rr_buffered.sv
// Randomised bench for switch_rr_buffered, checked against a queue-based model of
// the per-output arbitration, locking and buffering rules.
module tb_switch_rr_buffered;

    localparam int M  = 6;
    localparam int N  = 6;
    localparam int W  = 82;
    localparam int RL = 3;
    localparam int D  = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [M*W-1:0] in;
    logic [M*RL-1:0] route_in;
    logic [M-1:0]   in_valid;
    logic [M-1:0]   in_avail;
    logic [N-1:0]   out_valid;
    logic [N-1:0]   out_avail;
    logic [N*W-1:0] out;

    always #5 clk = ~clk;

    switch_rr_buffered #(
        .M_IN      (M),
        .N_OUT     (N),
        .FLIT_SIZE (W),
        .ROUTE_LEN (RL),
        .OUT_DEPTH (D),
        .PKT_LOCK  (1'b1),
        .HEAD_BIT  (W - 1),
        .TAIL_BIT  (W - 2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in        (in),
        .route_in  (route_in),
        .in_valid  (in_valid),
        .in_avail  (in_avail),
        .out_valid (out_valid),
        .out_avail (out_avail),
        .out       (out)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [W-1:0] mq [N][$];
    int           rr     [N];
    bit           locked [N];
    int           owner  [N];

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int j = 0; j < N; j++) begin
            mq[j].delete();
            rr[j]     = 0;
            locked[j] = 1'b0;
            owner[j]  = 0;
        end
    endtask

    function automatic int route_of(input int i);
        return int'(route_in[i*RL +: RL]);
    endfunction

    task automatic check_reset_state(input string tag);
        check({tag, "_in_avail"}, 512'(in_avail), 512'(0));
        check({tag, "_out_valid"}, 512'(out_valid), 512'(0));
        check({tag, "_out"}, 512'(out), 512'(0));
    endtask

    // Predict this cycle's outputs, compare, then advance the model across the next edge.
    task automatic check_and_step();
        logic [M-1:0]   exp_avail;
        logic [N-1:0]   exp_valid;
        logic [N*W-1:0] exp_out;
        logic [W-1:0]   f;
        int             gnt [N];
        exp_avail = '0;
        exp_valid = '0;
        exp_out   = '0;
        for (int j = 0; j < N; j++) begin
            gnt[j] = -1;
            if (mq[j].size() != 0) begin
                exp_valid[j]        = 1'b1;
                exp_out[j*W +: W]   = mq[j][0];
            end
            if (mq[j].size() < D) begin
                if (locked[j]) begin
                    if (in_valid[owner[j]] && route_of(owner[j]) == j + 1) gnt[j] = owner[j];
                end else begin
                    for (int k = 0; k < M; k++) begin
                        int i;
                        i = (rr[j] + k) % M;
                        if (gnt[j] < 0 && in_valid[i] && route_of(i) == j + 1) gnt[j] = i;
                    end
                end
            end
            if (gnt[j] >= 0) exp_avail[gnt[j]] = 1'b1;
        end
        check("in_avail", 512'(in_avail), 512'(exp_avail));
        check("out_valid", 512'(out_valid), 512'(exp_valid));
        check("out", 512'(out), 512'(exp_out));

        for (int j = 0; j < N; j++) begin
            if (mq[j].size() != 0 && out_avail[j]) void'(mq[j].pop_front());
            if (gnt[j] >= 0) begin
                f = in[gnt[j]*W +: W];
                mq[j].push_back(f);
                if (!locked[j]) begin
                    rr[j] = (gnt[j] + 1) % M;
                    if (f[W-1] && !f[W-2]) begin
                        locked[j] = 1'b1;
                        owner[j]  = gnt[j];
                    end
                end else if (f[W-2]) begin
                    locked[j] = 1'b0;
                    rr[j]     = (gnt[j] + 1) % M;
                end
            end
        end
    endtask

    task automatic drive(input int c);
        logic [95:0]  raw;
        logic [W-1:0] f;
        int           r;
        for (int i = 0; i < M; i++) begin
            in_valid[i] = ($urandom_range(0, 99) < 70);
            if (c < 1000)      r = $urandom_range(0, 7);
            else if (c < 1800) r = $urandom_range(1, 2);
            else               r = $urandom_range(1, 6);
            route_in[i*RL +: RL] = RL'(r);
            raw      = {$urandom, $urandom, $urandom};
            f        = raw[W-1:0];
            f[W-1]   = ($urandom_range(0, 99) < 35);
            f[W-2]   = ($urandom_range(0, 99) < 35);
            in[i*W +: W] = f;
        end
        for (int j = 0; j < N; j++) begin
            if (c >= 2500)                  out_avail[j] = 1'b1;
            else if (c >= 1000 && c < 1800) out_avail[j] = ($urandom_range(0, 99) < 25);
            else                            out_avail[j] = ($urandom_range(0, 99) < 75);
        end
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = '1;
        route_in  = {M{3'd1}};
        out_avail = '1;
        in        = '0;
        for (int i = 0; i < M; i++) in[i*W +: W] = W'(i + 1);
        model_reset();
        repeat (3) begin
            @(negedge clk);
            #1;
            check_reset_state("reset");
        end
        @(negedge clk);
        rst = 1'b1;

        for (int c = 0; c < 3000; c++) begin
            if (c == 1800) begin
                rst = 1'b0;
                #1;
                check_reset_state("midreset");
                model_reset();
                @(negedge clk);
                rst = 1'b1;
            end
            drive(c);
            #1;
            check_and_step();
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
